// File: rtl/ls27_test_sequencer.sv
// Self-test sequencer for the 74LS27 triple 3-input NOR block.
// Walks eight vectors through all three gates at once and gives each vector
// SETTLE_CYCLES of settle time. It then compares the gate outputs with the NOR
// function. Per-gate failures are sticky, and the first failing vector is kept.
//
// Control protocol: start is a level sampled only in IDLE; once accepted, busy
// rises on the next cycle and stays high through the DONE cycle. done is a
// single-cycle pulse in DONE. pass, fail_mask and first_fail are valid from
// the done pulse and hold until the next accepted start.
module ls27_test_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_out,
  output logic [8:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_mask,
  output logic [2:0] first_fail,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_e        state_q;
  logic [2:0]    vec_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sample_q;
  logic [8:0]    gate_in_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [2:0]    fail_mask_q;
  logic [2:0]    first_fail_q;

  logic [2:0]    mism;
  logic [2:0]    fail_mask_d;
  logic [2:0]    first_fail_d;

  // Gate k is driven with (vec+k) mod 8 as {c,b,a}; the 3-bit adds wrap naturally.
  function automatic logic [8:0] vec_to_pins(input logic [2:0] v);
    vec_to_pins = {v + 3'd2, v + 3'd1, v};
  endfunction

  // A NOR output is 1 only when all three of its inputs are 0.
  function automatic logic [2:0] nor_expect(input logic [2:0] v);
    logic [2:0] v1;
    logic [2:0] v2;
    v1 = v + 3'd1;
    v2 = v + 3'd2;
    nor_expect = {v2 == 3'd0, v1 == 3'd0, v == 3'd0};
  endfunction

  // Compare the captured outputs with the expected NOR values and fold the result into the sticky flags.
  always_comb begin
    mism         = sample_q ^ nor_expect(vec_q);
    fail_mask_d  = fail_mask_q | mism;
    first_fail_d = first_fail_q;
    if ((fail_mask_q == 3'd0) && (mism != 3'd0)) begin
      first_fail_d = vec_q;
    end
  end

  // Sequencer FSM with registered outputs.
  // gate_out is captured on the edge that enters CHECK, after exactly
  // SETTLE_CYCLES of stable inputs. The comparison then retires at CHECK's
  // closing edge, so the settle window is S*Tclk and not (S+1)*Tclk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 3'd0;
      cnt_q        <= '0;
      sample_q     <= 3'd0;
      gate_in_q    <= 9'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 3'd0;
      first_fail_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gate_in_q <= 9'd0;
          if (start) begin
            state_q      <= S_SETTLE;
            vec_q        <= 3'd0;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            fail_mask_q  <= 3'd0;
            first_fail_q <= 3'd0;
            gate_in_q    <= vec_to_pins(3'd0);
            busy_q       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            sample_q <= gate_out;
            state_q  <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          fail_mask_q  <= fail_mask_d;
          first_fail_q <= first_fail_d;
          if (vec_q != 3'd7) begin
            vec_q     <= vec_q + 3'd1;
            cnt_q     <= '0;
            gate_in_q <= vec_to_pins(vec_q + 3'd1);
            state_q   <= S_SETTLE;
          end else begin
            // pass is resolved on entry to DONE so that it is valid alongside the done pulse.
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            pass_q    <= (fail_mask_d == 3'd0);
            gate_in_q <= 9'd0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_in    = gate_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = fail_mask_q;
  assign first_fail = first_fail_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ls27_test_sequencer.sv
// Bench for ls27_test_sequencer: two sequencers (S=2 and S=3), each driving a
// delayed NOR bank with injectable stuck-at faults. Run results are predicted
// by a vector-level model of which inputs each sample sees.
`timescale 1ns/100ps
module tb_ls27_test_sequencer;

  localparam int CLK_NS = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start_a, start_b;
  logic [2:0] gout_a, gout_b;
  logic [8:0] gin_a, gin_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] fmask_a, fmask_b, ffail_a, ffail_b;
  logic [1:0] dbg_a, dbg_b;

  ls27_test_sequencer #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start_a), .gate_out(gout_a), .gate_in(gin_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(fmask_a),
    .first_fail(ffail_a), .dbg_state(dbg_a)
  );

  ls27_test_sequencer #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start_b), .gate_out(gout_b), .gate_in(gin_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(fmask_b),
    .first_fail(ffail_b), .dbg_state(dbg_b)
  );

  // Select which instance the driver tasks and checks look at.
  logic       sel;
  logic [8:0] obs_gin;
  logic       obs_busy, obs_done, obs_pass;
  logic [2:0] obs_fmask, obs_ffail;
  logic [1:0] obs_dbg;
  assign obs_gin   = sel ? gin_b   : gin_a;
  assign obs_busy  = sel ? busy_b  : busy_a;
  assign obs_done  = sel ? done_b  : done_a;
  assign obs_pass  = sel ? pass_b  : pass_a;
  assign obs_fmask = sel ? fmask_b : fmask_a;
  assign obs_ffail = sel ? ffail_b : ffail_a;
  assign obs_dbg   = sel ? dbg_b   : dbg_a;

  // ---------------- NOR bank model with transport delay ----------------
  int         dly_ns = 10;
  logic [2:0] f0 = 3'd0;   // stuck-at-0 per gate
  logic [2:0] f1 = 3'd0;   // stuck-at-1 per gate (wins over f0)
  logic [8:0] hist_a [0:63];
  logic [8:0] hist_b [0:63];

  function automatic logic [2:0] nor_bank(input logic [8:0] p);
    return {~|p[8:6], ~|p[5:3], ~|p[2:0]};
  endfunction

  // 1 ns input history, offset half a step from the clock edges.
  initial begin
    for (int i = 0; i < 64; i++) begin
      hist_a[i] = 9'd0;
      hist_b[i] = 9'd0;
    end
    #0.5;
    forever begin
      for (int i = 63; i > 0; i--) begin
        hist_a[i] = hist_a[i-1];
        hist_b[i] = hist_b[i-1];
      end
      hist_a[0] = gin_a;
      hist_b[0] = gin_b;
      #1;
    end
  end

  assign gout_a = (nor_bank(hist_a[dly_ns-1]) & ~f0) | f1;
  assign gout_b = (nor_bank(hist_b[dly_ns-1]) & ~f0) | f1;

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    n_total++;
    assert (obs === exp_q.pop_front()) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins presented for vector j: gate k gets (j+k) mod 8.
  function automatic logic [8:0] pins_for(input int j);
    return {3'((j + 2) % 8), 3'((j + 1) % 8), 3'(j % 8)};
  endfunction

  // The sample for each vector sees that vector's inputs if the gate delay fits
  // in s clock periods. Otherwise it sees the previous vector's inputs, and
  // vector 0 sees the idle all-zero inputs.
  function automatic void model_run(input int s, input int dly, input logic [2:0] fz,
                                    input logic [2:0] fo, output logic [2:0] mask,
                                    output logic [2:0] ff);
    mask = 3'd0;
    ff   = 3'd0;
    for (int v = 0; v < 8; v++) begin
      int src;
      logic [2:0] bad;
      src = (dly < s * CLK_NS) ? v : v - 1;
      bad = 3'd0;
      for (int k = 0; k < 3; k++) begin
        logic want, raw, seen;
        want = (((v + k) % 8) == 0);
        raw  = (src < 0) ? 1'b1 : (((src + k) % 8) == 0);
        seen = (raw & ~fz[k]) | fo[k];
        if (seen != want) bad[k] = 1'b1;
      end
      if (mask == 3'd0 && bad != 3'd0) ff = 3'(v);
      mask = mask | bad;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full run, called just after a negedge. restart_at > 0 raises start again during that cycle.
  task automatic do_run(input int s, input int restart_at, input string tag);
    logic [2:0] e_mask, e_ff;
    int last, done_cnt, done_cyc;
    model_run(s, dly_ns, f0, f1, e_mask, e_ff);
    last     = 8 * (s + 1) + 1;
    done_cnt = 0;
    done_cyc = -1;
    drive_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      drive_start(c == restart_at);
      if (c == 1) begin
        chk({tag, ".busy_c1"}, obs_busy, 1);
        chk({tag, ".pass_clr"}, obs_pass, 0);
        chk({tag, ".mask_clr"}, obs_fmask, 0);
      end
      if (c < last && ((c - 1) % (s + 1)) == 0)
        chk({tag, ".gate_in"}, obs_gin, pins_for((c - 1) / (s + 1)));
      if (obs_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == last) begin
        chk({tag, ".busy_done"}, obs_busy, 1);
        chk({tag, ".pass"}, obs_pass, (e_mask == 3'd0));
        chk({tag, ".fail_mask"}, obs_fmask, e_mask);
        if (e_mask != 3'd0) chk({tag, ".first_fail"}, obs_ffail, e_ff);
        chk({tag, ".gate_in_done"}, obs_gin, 0);
      end
    end
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".done_cycle"}, done_cyc, last);
    chk({tag, ".busy_after"}, obs_busy, 0);
    chk({tag, ".pass_held"}, obs_pass, (e_mask == 3'd0));
    chk({tag, ".mask_held"}, obs_fmask, e_mask);
    chk({tag, ".gate_in_after"}, obs_gin, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int done_seen;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    #1;
    chk("reset.busy", busy_a, 0);
    chk("reset.done", done_a, 0);
    chk("reset.pass", pass_a, 0);
    chk("reset.mask", fmask_a, 0);
    chk("reset.first", ffail_a, 0);
    chk("reset.gate_in", gin_a, 0);
    chk("reset.state", dbg_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Healthy bank, 10 ns delay
    do_run(2, 0, "healthy");
    idle(2);

    // y2 stuck at 0
    f0 = 3'b010;
    do_run(2, 0, "y2_sa0");
    f0 = 3'b000;
    idle(2);

    // y1 stuck at 1
    f1 = 3'b001;
    do_run(2, 0, "y1_sa1");
    f1 = 3'b000;
    idle(2);

    // Slow gates: 25 ns delay misses a 20 ns settle but fits in 30 ns
    dly_ns = 25;
    idle(5);
    do_run(2, 0, "slow_s2");
    sel = 1'b1;
    idle(5);
    do_run(3, 0, "slow_s3");
    sel = 1'b0;
    dly_ns = 10;
    idle(5);

    // start raised again mid-run is ignored
    do_run(2, 5, "restart");
    idle(2);

    // Reset in cycle 10 of a run aborts it with no done pulse
    start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", busy_a, 0);
    chk("abort.done", done_a, 0);
    chk("abort.pass", pass_a, 0);
    chk("abort.mask", fmask_a, 0);
    chk("abort.first", ffail_a, 0);
    chk("abort.gate_in", gin_a, 0);
    chk("abort.state", dbg_a, 0);
    done_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    chk("abort.no_done", done_seen, 0);
    do_run(2, 0, "post_abort");

    // Randomized fault patterns, gaps and mid-run restarts
    for (int r = 0; r < 8; r++) begin
      int rs;
      idle($urandom_range(1, 4));
      f0 = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      f1 = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0;
      do_run(2, rs, "random");
    end
    f0 = 3'd0;
    f1 = 3'd0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
